// File: rtl/decade_chain_ctrl_if.sv
// decade_chain_ctrl_if: command/status bundle for the decade counter.
// Optional lap input exists only when DECADE_LAP_HOLD_EN is defined.
interface decade_chain_ctrl_if;
    logic        start;
    logic        stop;
    logic        zero;
    logic [15:0] limit;
`ifdef DECADE_LAP_HOLD_EN
    logic        lap;
`endif
    logic [15:0] digits;
    logic        running;
    logic        done;
    logic        step;
    logic        rollover;

    modport slave (
`ifdef DECADE_LAP_HOLD_EN
        input  lap,
`endif
        input  start, stop, zero, limit,
        output digits, running, done, step, rollover
    );

    modport master (
`ifdef DECADE_LAP_HOLD_EN
        output lap,
`endif
        output start, stop, zero, limit,
        input  digits, running, done, step, rollover
    );
endinterface

// File: rtl/decade_chain_ctrl.sv
// decade_chain_ctrl: 4-digit BCD up-counter advancing once every PRESCALE
// clocks while running, with pause/resume, BCD terminal limit and rollover.
// Build option DECADE_LAP_HOLD_EN adds a lap input that freezes the
// displayed digits while counting continues internally.
module decade_chain_ctrl #(
    parameter int PRESCALE = 10
) (
    input  logic                 clk,
    input  logic                 clr,
    decade_chain_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_pre;
    logic [15:0] w_inc;
    logic        w_lim_ok;
    logic        w_step;

    // An advance happens only on a RUN cycle at the prescaler terminal value
    // that is not pre-empted by zero or stop.
    assign w_step = (r_state == S_RUN) && (r_pre == PRE_LAST) && !bus.zero && !bus.stop;

    // A limit is usable only if non-zero and every nibble is a BCD digit.
    assign w_lim_ok = (bus.limit != 16'h0000) &&
                      (bus.limit[3:0]   <= 4'd9) && (bus.limit[7:4]   <= 4'd9) &&
                      (bus.limit[11:8]  <= 4'd9) && (bus.limit[15:12] <= 4'd9);

    // BCD ripple increment: a digit moves only while every lower digit is 9.
    always_comb begin
        logic c;
        c     = 1'b1;
        w_inc = r_cnt;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r_cnt[i*4 +: 4] == 4'd9) begin
                    w_inc[i*4 +: 4] = 4'd0;
                end else begin
                    w_inc[i*4 +: 4] = r_cnt[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
    end

    // Control FSM with prescaler and live count; zero > stop > start.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pre   <= '0;
        end else if (bus.zero) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pre   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        r_state <= S_RUN;
                        r_pre   <= '0;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        r_state <= S_PAUSE;
                    end else if (w_step) begin
                        r_pre <= '0;
                        r_cnt <= w_inc;
                        if (w_lim_ok && (w_inc == bus.limit))
                            r_state <= S_DONE;
                    end else begin
                        r_pre <= r_pre + 16'd1;
                    end
                end
                S_PAUSE: begin
                    // Prescaler keeps its held value so the phase resumes.
                    if (bus.start && !bus.stop)
                        r_state <= S_RUN;
                end
                S_DONE: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.running  = (r_state == S_RUN);
    assign bus.done     = (r_state == S_DONE);
    assign bus.step     = w_step;
    assign bus.rollover = w_step && (r_cnt == 16'h9999);

`ifdef DECADE_LAP_HOLD_EN
    logic        r_hold;
    logic [15:0] r_snap;

    // Lap toggles the display freeze: capture in RUN, release on next lap or zero.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_hold <= 1'b0;
            r_snap <= '0;
        end else if (bus.zero) begin
            r_hold <= 1'b0;
        end else if (bus.lap) begin
            if (r_hold) begin
                r_hold <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_hold <= 1'b1;
                r_snap <= r_cnt;
            end
        end
    end

    assign bus.digits = r_hold ? r_snap : r_cnt;
`else
    assign bus.digits = r_cnt;
`endif

endmodule

// File: doc/decade_chain_ctrl.md
DECADE_CHAIN_CTRL -- requirements
Module: decade_chain_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 10: clk cycles per count step (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port clr, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1: run/resume command, sampled each edge.
REQ-005 SHALL have port stop, input, 1: pause command, sampled each edge.
REQ-006 SHALL have port zero, input, 1: synchronous clear of count to IDLE.
REQ-007 SHALL have port limit, input, 16: 4-digit BCD terminal value; 16'h0000 means no limit.
REQ-008 SHALL have port digits, output, 16: BCD count, [3:0] units, [15:12] thousands.
REQ-009 SHALL have port running, output, 1: high iff state is RUN.
REQ-010 SHALL have port done, output, 1: high iff state is DONE.
REQ-011 SHALL have port step, output, 1: one-cycle pulse on each cycle in which the count advances.
REQ-012 SHALL have port rollover, output, 1: one-cycle pulse in the cycle where 9999 advances to 0000.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE and DONE.
REQ-014 SHALL give commands the priority zero > stop > start.
REQ-015 SHALL move from any state to IDLE on zero, and SHALL clear the count and prescaler on the next edge.
REQ-016 SHALL move IDLE -> RUN on start and SHALL load the prescaler with 0.
REQ-017 SHALL move RUN -> PAUSE on stop, holding the count and prescaler value.
REQ-018 SHALL move PAUSE -> RUN on start and SHALL resume the prescaler from its held value.
REQ-019 SHALL ignore start in DONE; only zero or clr SHALL leave DONE.
REQ-020 SHALL keep the state unchanged when start and stop arrive together in IDLE or PAUSE.
REQ-021 SHALL advance the prescaler 0..PRESCALE-1 with wrap in RUN only, and SHALL assert step combinationally when state=RUN and prescaler=PRESCALE-1.
REQ-022 SHALL, on an edge with step=1, increment units; each higher digit SHALL increment only when all lower digits equal 9.
REQ-023 SHALL wrap each digit from 9 to 0; no digit SHALL ever hold a value above 9.
REQ-024 SHALL assert rollover together with step when digits=16'h9999, and SHALL make the next count 16'h0000 with the state staying RUN.
REQ-025 SHALL, when limit!=0 and the incremented value equals limit, load that value and enter DONE on the same edge.
REQ-026 SHALL make DONE reachable only by a step-driven match; a limit changed to equal the current count SHALL NOT trigger DONE.
REQ-027 SHALL make the first advance after start occur PRESCALE edges after the edge that sampled start; a start/step sampled on edge E is visible on the outputs after E.
REQ-028 SHALL let a stop sampled in a cycle with step=1 suppress that advance; PAUSE SHALL take priority over the advance.
REQ-029 SHALL not react to a limit that is not valid BCD (any nibble above 9); such a limit SHALL never match.

Reset
REQ-030 SHALL, while clr=1, force state IDLE, digits=0, prescaler=0, running=0, done=0, step=0 and rollover=0 (and the lap hold cleared when built in).
REQ-031 SHALL treat clr mid-RUN or mid-DONE like a power-on reset, and SHALL make the first edge after clr release an ordinary IDLE cycle.

Configuration
REQ-032 SHALL, with macro DECADE_LAP_HOLD_EN defined, add input lap (1 bit): a lap pulse in RUN freezes digits to a snapshot while counting continues internally, and the next lap or zero releases the freeze.
REQ-033 SHALL, with DECADE_LAP_HOLD_EN defined, generate running, done, step and rollover from the live count regardless of the freeze.
REQ-034 SHALL, without DECADE_LAP_HOLD_EN, omit the lap port and make digits always equal the live count.

Verification (PRESCALE=2)
REQ-035 SHALL cover: clr pulse, then start for 1 cycle -> running=1; digits=0001 two edges later, 0002 four edges later.
REQ-036 SHALL cover: count preset to 0999 via stepping, one further step -> digits=1000 with no rollover pulse.
REQ-037 SHALL cover: limit=0, stepping through 9999 -> rollover=1 for 1 cycle, digits=0000, running stays 1.
REQ-038 SHALL cover: limit=16'h0005 -> digits stop at 0005, done=1, running=0; start ignored; zero -> IDLE with digits=0000.
REQ-039 SHALL cover: stop in RUN with prescaler=1, then start 3 cycles later -> the advance occurs on the first edge after resume.
REQ-040 SHALL cover: clr asserted mid-RUN at count 0042 -> all outputs 0 immediately and state IDLE after release.
